// File: rtl/led_status_ctrl.sv
// Status-LED controller: error blink codes over disk-activity stretch over idle heartbeat,
// all paced by a prescaled time-base tick derived from the oscillator clock.
module led_status_ctrl #(
    parameter int unsigned TICK_DIV  = 20800,
    parameter int unsigned HB_HALF   = 50,
    parameter int unsigned ACT_TICKS = 5,
    parameter int unsigned ERR_ON    = 20,
    parameter int unsigned ERR_OFF   = 20,
    parameter int unsigned ERR_GAP   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hb_enable,
    input  logic       act_pulse,
    input  logic [2:0] err_code,
    output logic       led,
    output logic       tick,
    output logic [1:0] mode
);

    localparam int unsigned PreW  = $clog2(TICK_DIV + 1);
    localparam int unsigned HbW   = $clog2(HB_HALF + 1);
    localparam int unsigned ActW  = $clog2(ACT_TICKS + 1);
    localparam int unsigned PhMax = (ERR_ON > ERR_OFF) ?
                                    ((ERR_ON > ERR_GAP) ? ERR_ON : ERR_GAP) :
                                    ((ERR_OFF > ERR_GAP) ? ERR_OFF : ERR_GAP);
    localparam int unsigned PhW   = $clog2(PhMax + 1);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} err_st_e;

    logic [PreW-1:0] pre_q;
    logic            tick_q;
    logic [HbW-1:0]  hb_cnt_q;
    logic            hb_state_q;
    logic [ActW-1:0] act_cnt_q;
    err_st_e         st_q;
    logic [PhW-1:0]  ph_q;
    logic [2:0]      blinks_q;
    logic            led_q;
    logic [1:0]      mode_q;
    logic            pre_wrap;

    assign pre_wrap = (pre_q == PreW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= pre_wrap;
            pre_q  <= pre_wrap ? '0 : pre_q + 1'b1;
        end
    end

    // Heartbeat keeps running even while another source owns the LED.
    always_ff @(posedge clk) begin
        if (!rst_n || !hb_enable) begin
            hb_cnt_q   <= '0;
            hb_state_q <= 1'b0;
        end else if (tick_q) begin
            if (hb_cnt_q == HbW'(HB_HALF - 1)) begin
                hb_cnt_q   <= '0;
                hb_state_q <= ~hb_state_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_cnt_q <= '0;
        end else if (act_pulse) begin
            act_cnt_q <= ActW'(ACT_TICKS);
        end else if (tick_q && act_cnt_q != '0) begin
            act_cnt_q <= act_cnt_q - 1'b1;
        end
    end

    // err_code is only sampled when leaving IDLE or GAP, so a running code always completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= StIdle;
            ph_q     <= '0;
            blinks_q <= '0;
        end else if (tick_q) begin
            unique case (st_q)
                StIdle: begin
                    ph_q <= '0;
                    if (err_code != 3'd0) begin
                        st_q     <= StOn;
                        blinks_q <= err_code;
                    end
                end
                StOn: begin
                    if (ph_q == PhW'(ERR_ON - 1)) begin
                        st_q     <= StOff;
                        ph_q     <= '0;
                        blinks_q <= blinks_q - 1'b1;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                StOff: begin
                    if (ph_q == PhW'(ERR_OFF - 1)) begin
                        st_q <= (blinks_q == 3'd0) ? StGap : StOn;
                        ph_q <= '0;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                StGap: begin
                    if (ph_q == PhW'(ERR_GAP - 1)) begin
                        ph_q <= '0;
                        if (err_code != 3'd0) begin
                            st_q     <= StOn;
                            blinks_q <= err_code;
                        end else begin
                            st_q <= StIdle;
                        end
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q  <= 1'b0;
            mode_q <= 2'd0;
        end else if (st_q != StIdle) begin
            led_q  <= (st_q == StOn);
            mode_q <= 2'd2;
        end else if (act_cnt_q != '0) begin
            led_q  <= 1'b1;
            mode_q <= 2'd1;
        end else begin
            led_q  <= hb_state_q;
            mode_q <= 2'd0;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: directed scenarios then random traffic, every cycle compared
// against a tick-schedule reference model.
module tb_led_status_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int HB_HALF   = 2;
    localparam int ACT_TICKS = 3;
    localparam int ERR_ON    = 2;
    localparam int ERR_OFF   = 2;
    localparam int ERR_GAP   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hb_enable;
    logic       act_pulse;
    logic [2:0] err_code;
    logic       led;
    logic       tick;
    logic [1:0] mode;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: error sequence tracked as a tick position within one code period.
    int m_pre, m_hb_cnt, m_act, m_code, m_pos, m_mode;
    bit m_tick, m_hb, m_active, m_led;

    led_status_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .HB_HALF   (HB_HALF),
        .ACT_TICKS (ACT_TICKS),
        .ERR_ON    (ERR_ON),
        .ERR_OFF   (ERR_OFF),
        .ERR_GAP   (ERR_GAP)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hb_enable (hb_enable),
        .act_pulse (act_pulse),
        .err_code  (err_code),
        .led       (led),
        .tick      (tick),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    endtask

    task automatic model_step(input bit rst, input bit hb, input bit act, input int err);
        bit t;
        int seg;
        int len;
        if (!rst) begin
            m_pre = 0; m_tick = 0; m_hb_cnt = 0; m_hb = 0; m_act = 0;
            m_active = 0; m_code = 0; m_pos = 0; m_led = 0; m_mode = 0;
            return;
        end
        seg = ERR_ON + ERR_OFF;
        len = m_code * seg + ERR_GAP;
        if (m_active) begin
            m_mode = 2;
            m_led  = (m_pos < m_code * seg) && (m_pos % seg < ERR_ON);
        end else if (m_act > 0) begin
            m_mode = 1;
            m_led  = 1;
        end else begin
            m_mode = 0;
            m_led  = m_hb;
        end
        t      = m_tick;
        m_tick = (m_pre == TICK_DIV - 1);
        m_pre  = (m_pre + 1) % TICK_DIV;
        if (!hb) begin
            m_hb_cnt = 0;
            m_hb     = 0;
        end else if (t) begin
            m_hb_cnt++;
            if (m_hb_cnt == HB_HALF) begin
                m_hb_cnt = 0;
                m_hb     = !m_hb;
            end
        end
        if (act) m_act = ACT_TICKS;
        else if (t && m_act > 0) m_act--;
        if (t) begin
            if (!m_active) begin
                if (err != 0) begin
                    m_active = 1;
                    m_code   = err;
                    m_pos    = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == len) begin
                    if (err != 0) begin
                        m_code = err;
                        m_pos  = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step(rst_n, hb_enable, act_pulse, int'(err_code));
        check("led", int'(led), int'(m_led));
        check("tick", int'(tick), int'(m_tick));
        check("mode", int'(mode), m_mode);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int first_tick;
        rst_n = 1'b0; hb_enable = 1'b1; act_pulse = 1'b1; err_code = 3'd5;
        run(10);

        rst_n = 1'b1; hb_enable = 1'b0; act_pulse = 1'b0; err_code = 3'd0;
        first_tick = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (tick && first_tick == 0) first_tick = k;
        end
        check("first_tick_clk", first_tick, TICK_DIV);

        hb_enable = 1'b1;
        run(40);
        hb_enable = 1'b0;
        run(12);

        act_pulse = 1'b1; cycle(); act_pulse = 1'b0;
        run(9);
        act_pulse = 1'b1; cycle(); act_pulse = 1'b0;
        run(20);
        while (!tick) cycle();
        act_pulse = 1'b1; cycle(); act_pulse = 1'b0;
        run(20);

        err_code = 3'd2;
        run(6);
        err_code = 3'd3;
        run(100);
        err_code = 3'd2;
        run(60);
        err_code = 3'd0;
        run(60);

        err_code = 3'd1; act_pulse = 1'b1; hb_enable = 1'b1;
        run(14);
        err_code = 3'd0;
        run(30);
        act_pulse = 1'b0;
        run(20);

        err_code = 3'd1;
        run(10);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        run(30);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) err_code = 3'($urandom_range(7));
            if ($urandom_range(99) == 0) hb_enable = ~hb_enable;
            act_pulse = ($urandom_range(14) == 0);
            rst_n     = ($urandom_range(499) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
Status-LED controller that drives the board LED pin from the internal-oscillator clock domain. Arbitrates between three sources: error blink codes, disk-activity indication and an idle heartbeat. Generates its own slow time-base tick from the 2.08 MHz oscillator clock. Sits at top level between the disk controller status signals and the LED output pin.

Parameters:
TICK_DIV, 20800, clk cycles per time-base tick (2.08 MHz / 20800 = 10 ms)
HB_HALF, 50, ticks per heartbeat half-period (1 Hz blink)
ACT_TICKS, 5, activity stretch length in ticks (50 ms)
ERR_ON, 20, ticks LED on per error blink
ERR_OFF, 20, ticks LED off between error blinks
ERR_GAP, 100, ticks LED off after the last blink of a code

Ports:
clk  in  1  oscillator clock; one clock domain; all logic on posedge
rst_n  in  1  synchronous reset, active-low
hb_enable  in  1  1 = heartbeat runs; 0 = heartbeat held off
act_pulse  in  1  disk activity, level or pulse, sampled every clk
err_code  in  3  0 = no error; 1..7 = number of blinks per sequence
led  out  1  LED drive, registered, 1 = on
tick  out  1  one-clk time-base strobe
mode  out  2  active source: 0 = heartbeat, 1 = activity, 2 = error

Behaviour:
- Reset (rst_n = 0 at posedge): all counters 0, hb_state 0, act_cnt 0, FSM IDLE. Outputs: led = 0, tick = 0, mode = 0. Reset mid-sequence aborts immediately; led = 0 on the next cycle.
- Prescaler: pre_cnt counts 0..TICK_DIV-1 and wraps to 0. tick is registered: tick = 1 in the cycle after pre_cnt == TICK_DIV-1, else 0. After reset release the first tick is high at clk TICK_DIV. All counter widths are $clog2(param) sized, with no overflow.
- Heartbeat: on each tick, hb_cnt increments. At hb_cnt == HB_HALF-1, hb_cnt wraps to 0 and hb_state toggles. While hb_enable = 0, hb_cnt and hb_state are held at 0. Heartbeat runs even when not selected.
- Activity stretch:
  - Any clk with act_pulse = 1 loads act_cnt = ACT_TICKS (retrigger reloads).
  - Otherwise act_cnt decrements on tick while nonzero.
  - If act_pulse and tick coincide, the load wins.
  - act_on = (act_cnt != 0).
- Error FSM: states IDLE, ON, OFF, GAP. Transitions occur only on tick. ph_cnt counts ticks within a state and resets to 0 on every state change.
  - IDLE: on a tick with err_code != 0, go to ON. Latch code_lat = err_code and set blinks_left = err_code.
  - ON: at ph_cnt == ERR_ON-1 on a tick, go to OFF and decrement blinks_left.
  - OFF: at ph_cnt == ERR_OFF-1 on a tick, go to GAP if blinks_left == 0, else go to ON.
  - GAP: at ph_cnt == ERR_GAP-1 on a tick, go to ON if err_code != 0 (relatch code and blinks_left), else go to IDLE.
  - A change to err_code mid-sequence, including a change to 0, does not alter the current sequence. The new value is sampled only at IDLE/GAP exit.
- Arbitration (registered, 1-clk latency from internal state):
  - FSM != IDLE: mode = 2, led = 1 only in ON, else 0.
  - Else if act_on: mode = 1, led = 1 (solid).
  - Else: mode = 0, led = hb_state.
- Error has absolute priority; activity and heartbeat state keep evolving underneath it.

Test Plan:
(Bench parameters for all scenarios: TICK_DIV = 4, HB_HALF = 2, ACT_TICKS = 3, ERR_ON = 2, ERR_OFF = 2, ERR_GAP = 4.)
1. Reset: rst_n = 0 for 10 clk with act_pulse = 1, err_code = 5, hb_enable = 1 -> led = 0, tick = 0, mode = 0 throughout. After release with inputs 0, tick first high at clk 4, then every 4 clk.
2. Heartbeat: hb_enable = 1, other inputs 0 -> mode = 0, led toggles every 8 clk (2 ticks). Drop hb_enable -> led = 0 within 2 clk, and it stays 0.
3. Activity: single-clk act_pulse -> mode = 1 and led = 1 from the next clk until the 3rd subsequent tick (+1 clk), then mode = 0. A second pulse after 2 ticks extends led = 1 for 3 more ticks. A pulse coincident with a tick reloads to 3, not 2.
4. Error code 2 -> pattern ON 8 clk, OFF 8, ON 8, OFF 8, GAP 16, then repeats while err_code = 2. Setting err_code = 3 during the first ON gives 2 blinks in the current sequence and 3 in the next.
5. Priority: act_pulse held 1 and hb_enable = 1 while err_code = 1 -> mode = 2 throughout the sequence. Set err_code = 0 during OFF -> sequence finishes through GAP, then mode = 1 (act still on); release act -> mode = 0 after 3 ticks.
6. Reset mid-error: assert rst_n = 0 for 1 clk during ON -> led = 0 and mode = 0 next clk. With err_code still 1 after release, ON re-enters at the first tick (clk 4 after release).
